// File: rtl/smadd_pkg.sv
// Shared types, default sizes and the sign-magnitude add/sub helper for smadd_scheduler.
package smadd_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 18;
    // Working magnitude width of the helper; callers zero-extend and keep the low bits they need.
    localparam int SM_MAGW  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic               sign;
        logic [SM_MAGW:0]   mag;
    } sm_res_t;

    function automatic sm_res_t sm_addsub(
        input logic               p_sign,
        input logic [SM_MAGW-1:0] p_mag,
        input logic               q_sign,
        input logic [SM_MAGW-1:0] q_mag,
        input logic               sub
    );
        logic    ps;
        logic    qs;
        sm_res_t r;
        // A zero magnitude is +0 whatever its sign bit says; subtraction flips Q's sign.
        ps = p_sign & (|p_mag);
        qs = (q_sign ^ sub) & (|q_mag);
        if (ps == qs) begin
            r.sign = ps;
            r.mag  = {1'b0, p_mag} + {1'b0, q_mag};
        end else if (p_mag >= q_mag) begin
            r.sign = ps;
            r.mag  = {1'b0, p_mag - q_mag};
        end else begin
            r.sign = qs;
            r.mag  = {1'b0, q_mag - p_mag};
        end
        if (r.mag == '0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/smadd_rr_arb.sv
// Round-robin arbiter: searches from ptr_i+1 upward, wrapping, and returns a one-hot grant plus its index.
module smadd_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/smadd_scheduler.sv
// Round-robin scheduler feeding a shared sign-magnitude adder/subtractor (IDLE -> EXEC -> RESP).
// Optional completed-operation counter on op_count is built only when SMADD_STATS_EN is defined.
module smadd_scheduler
    import smadd_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int W    = DEF_W,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_p,
    input  logic [NREQ*W-1:0] req_q,
    input  logic [NREQ-1:0]   req_mode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic [15:0]       op_count
);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic            rsp_valid_q;
    logic [W:0]      rsp_sum_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [W-1:0]    op_p_q;
    logic [W-1:0]    op_q_q;
    logic            op_sub_q;
    logic [IDW-1:0]  gnt_id_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    sm_res_t         res;
    logic            unused_mag_hi;

    smadd_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // The grant strobe is the accept handshake itself, so it must be visible in the same IDLE cycle.
    assign req_ready = (state_q == IDLE && !wb_rst_i) ? grant : '0;

    assign res = sm_addsub(op_p_q[W-1], SM_MAGW'(op_p_q[W-2:0]),
                           op_q_q[W-1], SM_MAGW'(op_q_q[W-2:0]), op_sub_q);
    assign unused_mag_hi = ^res.mag[SM_MAGW:W];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum_q   <= {res.sign, res.mag[W-1:0]};
                    rsp_id_q    <= gnt_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= rsp_id_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: operand latches carry no reset; they are always written at grant before EXEC reads them.
    always_ff @(posedge wb_clk_i) begin
        if (state_q == IDLE && grant_any) begin
            op_p_q   <= req_p[int'(grant_idx)*W +: W];
            op_q_q   <= req_q[int'(grant_idx)*W +: W];
            op_sub_q <= req_mode[grant_idx];
            gnt_id_q <= grant_idx;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

`ifdef SMADD_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            op_count_q <= '0;
        end else if (rsp_valid_q && rsp_ready && op_count_q != 16'hFFFF) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: doc/smadd_scheduler.md
SMADD_SCHEDULER -- requirements
Module: smadd_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 18, operand width in sign-magnitude form (bit W-1 sign, W-2:0 magnitude).
REQ-003 SHALL have port wb_clk_i  in  1  sole clock, rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  out  NREQ  per-requester accept strobe, one-hot or zero.
REQ-007 SHALL have port req_p  in  NREQ*W  packed operand P, requester i at [i*W +: W].
REQ-008 SHALL have port req_q  in  NREQ*W  packed operand Q, same packing.
REQ-009 SHALL have port req_mode  in  NREQ  per-requester op: 0 = P+Q, 1 = P-Q.
REQ-010 SHALL have port rsp_valid  out  1  result available.
REQ-011 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-012 SHALL have port rsp_sum  out  W+1  result, sign-magnitude (bit W sign, W-1:0 magnitude).
REQ-013 SHALL have port rsp_id  out  clog2(NREQ)  index of the requester that owns rsp_sum.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port op_count  out  16  completed-operation counter (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-017 IDLE: if any req_valid is high, SHALL grant exactly one requester by round-robin, searching from last-granted index+1, wrapping NREQ-1 -> 0.
REQ-018 In the grant cycle SHALL assert req_ready[g] for exactly one cycle, latch req_p/req_q/req_mode/g, and go to EXEC; the request is accepted on req_valid[g] & req_ready[g].
REQ-019 EXEC: SHALL compute the sign-magnitude result from the latched operands in one cycle, register it into rsp_sum/rsp_id, and go to RESP.
REQ-020 RESP: SHALL hold rsp_valid=1 and stable rsp_sum/rsp_id until rsp_ready=1; on that edge SHALL drop rsp_valid, update the last-granted pointer to g, and return to IDLE.
REQ-021 Latency: accept edge to rsp_valid = 2 cycles; best-case throughput = one operation per 3 cycles.
REQ-022 req_ready SHALL be 0 in EXEC and RESP, regardless of req_valid.
REQ-023 Arithmetic: operands with magnitude 0 SHALL be treated as +0 regardless of sign bit; the result magnitude is exact over W bits (no overflow is possible).
REQ-024 A zero result SHALL always carry sign 0 (no negative zero).
REQ-025 A requester deasserting req_valid before grant SHALL lose no state; it is simply skipped.
REQ-026 If only one requester is valid, it SHALL be granted on every IDLE visit (no starvation gaps).

Reset
REQ-027 On wb_rst_i=1, immediately and asynchronously: state=IDLE, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0, last-granted pointer=NREQ-1 (so requester 0 wins first), op_count=0.
REQ-028 Reset mid-operation SHALL discard the in-flight operation with no response issued.

Configuration
REQ-029 With macro SMADD_STATS_EN defined, op_count SHALL increment by 1 on each rsp_valid & rsp_ready handshake, saturating at 16'hFFFF.
REQ-030 Without SMADD_STATS_EN, op_count SHALL be constant 0 and no counter flops SHALL be built.

Structure
REQ-031 A shared package smadd_pkg SHALL hold the FSM state enum (IDLE, EXEC, RESP), default W/NREQ constants and the sign-magnitude add/sub function.
REQ-032 Round-robin grant logic SHALL be the one sub-module smadd_rr_arb (inputs: request vector, pointer; output: one-hot grant + index).

Verification
REQ-033 Single op: req0 P=0x00005 (+5), Q=0x20003 (-3), mode=0, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_sum=0x00002, rsp_id=0.
REQ-034 Subtract/sign: P=+3, Q=+5, mode=1 -> rsp_sum=0x40002 (-2); P=+0x1FFFF, Q=-0x1FFFF, mode=1 -> rsp_sum=0x3FFFE.
REQ-035 Negative zero: P=0x20000, Q=0x00000, mode=0 -> rsp_sum=0x00000; P=+7, Q=+7, mode=1 -> 0x00000.
REQ-036 Fairness: all 4 req_valid held high for 8 operations -> rsp_id sequence 0,1,2,3,0,1,2,3.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_sum stable, all req_ready=0; release -> return to IDLE next edge; with SMADD_STATS_EN op_count increments once.
REQ-038 Async reset asserted in EXEC -> outputs at reset values without a clock edge, no response issued afterward, next grant goes to requester 0.
